// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and memory map defaults for the data memory responder
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DEFAULT_IO_BASE   = 32'h1001_0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_formatter.sv
// rtl/data_mem_responder_formatter.sv - combinational store lane steering, load extraction and alignment check
module load_store_formatter
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wbe,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rword[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
        wbe       = 4'b0000;
        wdata_rep = wdata;
        load_val  = 32'h0;
        misalign  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                wbe       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_val  = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                misalign  = addr_lo[0];
                wbe       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                load_val  = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                misalign = |addr_lo;
                wbe      = 4'b1111;
                load_val = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-side responder: request FSM, address decode, word RAM and GPIO registers
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter logic [31:0] DATA_BASE  = DEFAULT_DATA_BASE,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
    parameter int          GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  Ready,
    output logic                  Fault,
    input  logic [GPIO_WIDTH-1:0] GPIO_In,
    output logic [GPIO_WIDTH-1:0] GPIO_Out
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    state_t                state;
    logic                  phase;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_f3;
    logic                  req_rd;
    logic                  req_wr;
    logic [31:0]           rword_q;
    logic [GPIO_WIDTH-1:0] gpio_meta;
    logic [GPIO_WIDTH-1:0] gpio_sync;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           ram_off;
    logic [31:0]           io_off;
    logic                  in_ram;
    logic                  in_io;
    logic                  io_in_sel;
    logic                  f3_ok;
    logic                  misalign;
    logic                  bad;
    logic                  ram_we;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            wbe;
    logic [31:0]           wdata_rep;
    logic [31:0]           load_val;

    // Subtract-then-compare keeps each region check a single unsigned compare, immune to wrap.
    assign ram_off   = req_addr - DATA_BASE;
    assign io_off    = req_addr - IO_BASE;
    assign in_ram    = ram_off < RAM_BYTES;
    assign in_io     = io_off < 32'd8;
    assign io_in_sel = io_off[2];
    assign idx       = ram_off[IDX_W+1:2];
    assign f3_ok     = req_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    assign bad = (req_rd & req_wr) | ~f3_ok | (req_wr & req_f3[2]) | misalign
               | ~(in_ram | in_io)
               | (in_io & (req_f3 != F3_W))
               | (in_io & req_wr & io_in_sel);

    assign ram_we = (state == ACCESS) & phase & ~bad & in_ram & ~in_io & req_wr;

    load_store_formatter u_fmt (
        .funct3    (req_f3),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .rword     (rword_q),
        .wbe       (wbe),
        .wdata_rep (wdata_rep),
        .load_val  (load_val),
        .misalign  (misalign)
    );

    // Synchronous-read RAM: the first ACCESS cycle fetches the word, the second merges lanes and commits.
    always_ff @(posedge clk) begin
        if (state == ACCESS && !phase)
            rword_q <= mem[idx];
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (wbe[i])
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= 1'b0;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            req_f3    <= 3'b000;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            Ready     <= 1'b0;
            Fault     <= 1'b0;
            ReadData  <= 32'h0;
            GPIO_Out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= GPIO_In;
            gpio_sync <= gpio_meta;
            case (state)
                IDLE: begin
                    Ready <= 1'b0;
                    if (MemRead | MemWrite) begin
                        req_addr  <= Address;
                        req_wdata <= WriteData;
                        req_f3    <= Funct3;
                        req_rd    <= MemRead;
                        req_wr    <= MemWrite;
                        phase     <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        state    <= RESP;
                        Ready    <= 1'b1;
                        Fault    <= bad;
                        ReadData <= 32'h0;
                        if (!bad) begin
                            if (in_io) begin
                                if (req_wr)
                                    GPIO_Out <= req_wdata[GPIO_WIDTH-1:0];
                                else if (io_in_sel)
                                    ReadData <= {{(32-GPIO_WIDTH){1'b0}}, gpio_sync};
                                else
                                    ReadData <= {{(32-GPIO_WIDTH){1'b0}}, GPIO_Out};
                            end else if (req_rd) begin
                                ReadData <= load_val;
                            end
                        end
                    end
                end
                RESP: begin
                    Ready    <= 1'b0;
                    Fault    <= 1'b0;
                    ReadData <= 32'h0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
